// File: rtl/regfile_if.sv
// Writeback commit, decode read and issue-scoreboard signals of the register file.
interface regfile_if #(
    parameter int unsigned W  = 32,
    parameter int unsigned AW = 5
);
    logic          write_en;
    logic [AW-1:0] reg_write_addr;
    logic [W-1:0]  reg_write_data;
    logic [AW-1:0] raddr1;
    logic [AW-1:0] raddr2;
    logic [W-1:0]  rdata1;
    logic [W-1:0]  rdata2;
    logic          issue_en;
    logic [AW-1:0] issue_addr;
    logic          busy1;
    logic          busy2;
    logic          pend_full;

    modport master (
        output write_en, reg_write_addr, reg_write_data, raddr1, raddr2, issue_en, issue_addr,
        input  rdata1, rdata2, busy1, busy2, pend_full
    );

    modport slave (
        input  write_en, reg_write_addr, reg_write_data, raddr1, raddr2, issue_en, issue_addr,
        output rdata1, rdata2, busy1, busy2, pend_full
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// MIPS32 register file with per-register pending-write counters for RAW stall detection.
// Define RF_WB_BYPASS_EN to forward the committing writeback value to the read ports.
module regfile_scoreboard #(
    parameter int unsigned W      = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned PEND_W = 2
) (
    input logic       clk,
    input logic       rst,
    regfile_if.slave  rf
);
    localparam int unsigned AW = $clog2(NREG);
    localparam logic [PEND_W-1:0] PendMax = '1;

    logic [W-1:0]      regs_q [NREG];
    logic [PEND_W-1:0] pend_q [NREG];
    logic [PEND_W-1:0] pend_d [NREG];
    logic              pend_full;
    logic              wr_valid;

    assign wr_valid  = rf.write_en && (rf.reg_write_addr != '0);
    assign pend_full = (rf.issue_addr != '0) && (pend_q[rf.issue_addr] == PendMax);

    // A dropped issue (pend_full) never increments; a commit never drives a counter below zero.
    always_comb begin
        pend_d = pend_q;
        for (int r = 1; r < NREG; r++) begin
            if ((rf.issue_en && rf.issue_addr == AW'(r) && !pend_full) &&
                !(rf.write_en && rf.reg_write_addr == AW'(r) && pend_q[r] != '0)) begin
                pend_d[r] = pend_q[r] + 1'b1;
            end else if (!(rf.issue_en && rf.issue_addr == AW'(r) && !pend_full) &&
                         (rf.write_en && rf.reg_write_addr == AW'(r) && pend_q[r] != '0)) begin
                pend_d[r] = pend_q[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
                pend_q[r] <= '0;
            end
        end else begin
            if (wr_valid) begin
                regs_q[rf.reg_write_addr] <= rf.reg_write_data;
            end
            pend_q <= pend_d;
        end
    end

`ifdef RF_WB_BYPASS_EN
    logic fwd1, fwd2;

    assign fwd1 = wr_valid && (rf.reg_write_addr == rf.raddr1);
    assign fwd2 = wr_valid && (rf.reg_write_addr == rf.raddr2);

    // The committing write no longer counts as pending once its value is forwarded.
    always_comb begin
        rf.rdata1 = (rf.raddr1 == '0) ? '0 : regs_q[rf.raddr1];
        rf.rdata2 = (rf.raddr2 == '0) ? '0 : regs_q[rf.raddr2];
        rf.busy1  = (pend_q[rf.raddr1] != '0);
        rf.busy2  = (pend_q[rf.raddr2] != '0);
        if (fwd1) begin
            rf.rdata1 = rf.reg_write_data;
            rf.busy1  = (pend_q[rf.raddr1] > PEND_W'(1));
        end
        if (fwd2) begin
            rf.rdata2 = rf.reg_write_data;
            rf.busy2  = (pend_q[rf.raddr2] > PEND_W'(1));
        end
    end
`else
    always_comb begin
        rf.rdata1 = (rf.raddr1 == '0) ? '0 : regs_q[rf.raddr1];
        rf.rdata2 = (rf.raddr2 == '0) ? '0 : regs_q[rf.raddr2];
        rf.busy1  = (pend_q[rf.raddr1] != '0);
        rf.busy2  = (pend_q[rf.raddr2] != '0);
    end
`endif

    assign rf.pend_full = pend_full;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus randomized traffic
// against an array-based reference model.
module tb_regfile_scoreboard;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    // Reference model: register contents and count of outstanding writes per register.
    logic [31:0] m_regs [32];
    int          m_pend [32];

    regfile_if #(.W(32), .AW(5)) rf ();

    regfile_scoreboard #(.W(32), .NREG(32), .PEND_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 0;
        end
    endfunction

    function automatic logic [31:0] exp_rdata(int a);
        if (a == 0) return '0;
`ifdef RF_WB_BYPASS_EN
        if (rf.write_en && int'(rf.reg_write_addr) == a) return rf.reg_write_data;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(int a);
        if (a == 0) return 1'b0;
`ifdef RF_WB_BYPASS_EN
        if (rf.write_en && int'(rf.reg_write_addr) == a) return m_pend[a] > 1;
`endif
        return m_pend[a] != 0;
    endfunction

    function automatic logic exp_full();
        return (rf.issue_addr != 0) && (m_pend[rf.issue_addr] == 3);
    endfunction

    task automatic drive(input logic we, input int wa, input logic [31:0] wd,
                         input logic ie, input int ia, input int r1, input int r2);
        rf.write_en       = we;
        rf.reg_write_addr = 5'(wa);
        rf.reg_write_data = wd;
        rf.issue_en       = ie;
        rf.issue_addr     = 5'(ia);
        rf.raddr1         = 5'(r1);
        rf.raddr2         = 5'(r2);
        #1;
    endtask

    // Advance the model by the current inputs, then take one clock edge.
    task automatic tick();
        int  wa, ia;
        logic inc, dec;
        wa = int'(rf.reg_write_addr);
        ia = int'(rf.issue_addr);
        if (!rst) begin
            inc = rf.issue_en && ia != 0 && m_pend[ia] < 3;
            dec = rf.write_en && wa != 0 && m_pend[wa] > 0;
            if (rf.write_en && wa != 0) m_regs[wa] = rf.reg_write_data;
            if (inc) m_pend[ia]++;
            if (dec) m_pend[wa]--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_clear();
        drive(1'b0, 0, '0, 1'b0, 0, 5, 9);
        n_tests++;
        if (rf.rdata1 !== 32'h0 || rf.rdata2 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h/%h want 0/0", rf.rdata1, rf.rdata2);
        end
        n_tests++;
        if (rf.busy1 !== 1'b0 || rf.busy2 !== 1'b0 || rf.pend_full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got busy %b%b full %b want 000",
                     rf.busy1, rf.busy2, rf.pend_full);
        end
        tick();
        rst = 1'b0;
        // Write and issue r5, then reset asynchronously mid-cycle.
        drive(1'b1, 5, 32'h1234, 1'b1, 5, 5, 0);
        tick();
        drive(1'b0, 0, '0, 1'b0, 0, 5, 0);
        n_tests++;
        if (rf.rdata1 !== 32'h1234 || rf.busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_r5: got %h busy %b want 00001234 busy 1", rf.rdata1, rf.busy1);
        end
        #2 rst = 1'b1;
        model_clear();
        #1;
        n_tests++;
        if (rf.rdata1 !== 32'h0 || rf.busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_r5: got %h busy %b want 0 busy 0", rf.rdata1, rf.busy1);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_r0();
        drive(1'b1, 0, 32'hFFFF_FFFF, 1'b1, 0, 0, 0);
        n_tests++;
        if (rf.pend_full !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_full: got %b want 0", rf.pend_full);
        end
        tick();
        drive(1'b0, 0, '0, 1'b1, 0, 0, 0);
        n_tests++;
        if (rf.rdata1 !== 32'h0 || rf.busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_read: got %h busy %b want 0 busy 0", rf.rdata1, rf.busy1);
        end
        tick();
        drive(1'b0, 0, '0, 1'b0, 0, 0, 0);
        n_tests++;
        if (rf.busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_busy: got %b want 0", rf.busy1);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] old;
        drive(1'b1, 7, 32'h0BAD_F00D, 1'b0, 0, 0, 0);
        tick();
        old = 32'h0BAD_F00D;
        drive(1'b1, 7, 32'hDEAD_BEEF, 1'b0, 0, 0, 7);
`ifdef RF_WB_BYPASS_EN
        old = 32'hDEAD_BEEF;
`endif
        n_tests++;
        if (rf.rdata2 !== old) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: got %h want %h", rf.rdata2, old);
        end
        tick();
        drive(1'b0, 0, '0, 1'b0, 0, 0, 7);
        n_tests++;
        if (rf.rdata2 !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL bypass_next_cycle: got %h want deadbeef", rf.rdata2);
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 0, '0, 1'b1, 3, 3, 0);
            tick();
        end
        drive(1'b0, 0, '0, 1'b1, 3, 3, 0);
        n_tests++;
        if (rf.pend_full !== 1'b1 || rf.busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_full: got full %b busy %b want 1 1", rf.pend_full, rf.busy1);
        end
        tick();
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 3, 32'h300 + 32'(k), 1'b0, 0, 3, 0);
            tick();
            drive(1'b0, 0, '0, 1'b0, 3, 3, 0);
            n_tests++;
            if (rf.busy1 !== (k < 3) || rf.pend_full !== 1'b0) begin
                n_fail++;
                $display("FAIL sat_commit%0d: got busy %b full %b want %b 0",
                         k, rf.busy1, rf.pend_full, k < 3);
            end
        end
    endtask

    task automatic test_issue_commit_same();
        logic [31:0] d;
        d = $urandom;
        drive(1'b0, 0, '0, 1'b1, 9, 9, 0);
        tick();
        drive(1'b1, 9, d, 1'b1, 9, 9, 0);
        tick();
        drive(1'b0, 0, '0, 1'b0, 0, 9, 0);
        n_tests++;
        if (rf.busy1 !== 1'b1 || rf.rdata1 !== d) begin
            n_fail++;
            $display("FAIL same_cycle_r9: got %h busy %b want %h busy 1", rf.rdata1, rf.busy1, d);
        end
    endtask

    task automatic test_underflow();
        drive(1'b1, 12, 32'hC0FF_EE12, 1'b0, 0, 12, 0);
        tick();
        drive(1'b0, 0, '0, 1'b0, 12, 12, 0);
        n_tests++;
        if (rf.rdata1 !== 32'hC0FF_EE12 || rf.busy1 !== 1'b0 || rf.pend_full !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_r12: got %h busy %b full %b want c0ffee12 0 0",
                     rf.rdata1, rf.busy1, rf.pend_full);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            n_tests++;
            if (rf.rdata1 !== exp_rdata(int'(rf.raddr1))) begin
                n_fail++;
                $display("FAIL rand_rdata1 c%0d: got %h want %h",
                         c, rf.rdata1, exp_rdata(int'(rf.raddr1)));
            end
            n_tests++;
            if (rf.rdata2 !== exp_rdata(int'(rf.raddr2))) begin
                n_fail++;
                $display("FAIL rand_rdata2 c%0d: got %h want %h",
                         c, rf.rdata2, exp_rdata(int'(rf.raddr2)));
            end
            n_tests++;
            if (rf.busy1 !== exp_busy(int'(rf.raddr1)) || rf.busy2 !== exp_busy(int'(rf.raddr2)))
            begin
                n_fail++;
                $display("FAIL rand_busy c%0d: got %b%b want %b%b", c, rf.busy1, rf.busy2,
                         exp_busy(int'(rf.raddr1)), exp_busy(int'(rf.raddr2)));
            end
            n_tests++;
            if (rf.pend_full !== exp_full()) begin
                n_fail++;
                $display("FAIL rand_full c%0d: got %b want %b", c, rf.pend_full, exp_full());
            end
            tick();
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_r0();
        test_bypass();
        test_saturation();
        test_issue_commit_same();
        test_underflow();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
